// File: rtl/clk_rst_ctrl_pkg.sv
// Shared types for the clock/reset controller: FSM states, reset cause codes,
// and the saturating event-counter increment.
package clk_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_LOCK = 2'b01,
    CAUSE_BTN  = 2'b10
  } cause_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_rst_ctrl_btn_debounce.sv
// Button conditioner: synchroniser chain, stability counter and a one-cycle
// press strobe on the debounced falling edge. Reused for other board buttons.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 30_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic btn_db_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   db_q;
  logic                   db_prev_q;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Synchroniser; idles high so a reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
    end else begin
      db_prev_q <= db_q;
      if (btn_s == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        db_q  <= btn_s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign btn_db_o = db_q;
  assign press_o  = db_prev_q & ~db_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// SoC reset controller downstream of the PLL: combines lock, button and rst
// into a registered sys_rst, records the reset cause, counts lock losses and
// generates a 1 us tick while the SoC is running.
module clk_rst_ctrl
  import clk_rst_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 30_000_000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 30_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       btn_n,
  output logic       sys_rst,
  output logic       locked,
  output logic [1:0] rst_cause,
  output logic [7:0] lock_loss_cnt,
  output logic       tick_us
);

  localparam int TICK_P = CLK_HZ / 1_000_000;
  localparam int TW     = $clog2(TICK_P);
  localparam int HW     = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_P - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_q;
  logic                   btn_db;
  logic                   press;
  logic                   btn_held_q;

  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  cause_e                 cause_q, cause_d;
  logic [7:0]             loss_cnt_q, loss_cnt_d;
  logic                   sys_rst_q, sys_rst_d;
  logic [TW-1:0]          tick_cnt_q;
  logic                   tick_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_n_i  (btn_n),
    .btn_db_o (btn_db),
    .press_o  (press)
  );

  // Lock synchroniser plus output register; button level registered the same
  // way so both release paths see one extra cycle before HOLD starts counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q <= '0;
      locked_q    <= 1'b0;
      btn_held_q  <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
      locked_q    <= lock_sync_q[SYNC_STAGES-1];
      btn_held_q  <= ~btn_db;
    end
  end

  // Next state, hold counter, cause and lock-loss counter; lock loss has
  // priority over a press in RUN.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    loss_cnt_d = loss_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        hold_cnt_d = '0;
        if (locked_q && !btn_held_q) state_d = HOLD;
      end
      HOLD: begin
        if (!locked_q) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (btn_held_q) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_q) begin
          state_d    = WAIT_LOCK;
          cause_d    = CAUSE_LOCK;
          loss_cnt_d = sat_inc8(loss_cnt_q);
        end else if (press) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          cause_d    = CAUSE_BTN;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase
    sys_rst_d = (state_d != RUN);
  end

  // FSM and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
      cause_q    <= CAUSE_POR;
      loss_cnt_q <= '0;
      sys_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cause_q    <= cause_d;
      loss_cnt_q <= loss_cnt_d;
      sys_rst_q  <= sys_rst_d;
    end
  end

  // 1 us tick: idle while in reset or entering/leaving it, so the first pulse
  // lands TICK_P cycles after sys_rst falls and none overlaps sys_rst=1.
  always_ff @(posedge clk) begin
    if (rst || sys_rst_q || sys_rst_d) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_q     <= (tick_cnt_q == TICK_LAST);
      tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign locked        = locked_q;
  assign rst_cause     = cause_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign tick_us       = tick_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed bench for clk_rst_ctrl with small parameters (P=4, hold 16,
// debounce 8, 2 sync stages). Inputs change and outputs are sampled 1 ns
// after the rising edge.
module tb_clk_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       btn_n;
  logic       sys_rst;
  logic       locked;
  logic [1:0] rst_cause;
  logic [7:0] lock_loss_cnt;
  logic       tick_us;

  int errors = 0;
  int checks = 0;
  int rises  = 0;
  logic prev_rst;

  clk_rst_ctrl #(
    .CLK_HZ          (4_000_000),
    .HOLD_CYCLES     (16),
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .btn_n         (btn_n),
    .sys_rst       (sys_rst),
    .locked        (locked),
    .rst_cause     (rst_cause),
    .lock_loss_cnt (lock_loss_cnt),
    .tick_us       (tick_us)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold btn_n at v for n cycles, counting sys_rst rising edges.
  task automatic drive_btn(input logic v, input int n);
    btn_n = v;
    repeat (n) begin
      step();
      if (sys_rst && !prev_rst) rises++;
      prev_rst = sys_rst;
    end
  endtask

  // Drop lock in RUN, then relock; report cycles to sys_rst rise and fall.
  task automatic lose_relock(output int t_rst, output int t_run);
    int n;
    pll_lock = 1'b0;
    n = 0;
    while (!sys_rst && n < 20) begin step(); n++; end
    t_rst = n;
    pll_lock = 1'b1;
    n = 0;
    while (sys_rst && n < 60) begin step(); n++; end
    t_run = n;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1; pll_lock = 1'b0; btn_n = 1'b1;
    repeat (3) step();
    checks++;
    if (sys_rst !== 1'b1 || locked !== 1'b0 || rst_cause !== 2'b00 ||
        lock_loss_cnt !== 8'd0 || tick_us !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sys_rst=%b locked=%b cause=%b cnt=%0d tick=%b, want 1 0 00 0 0",
               sys_rst, locked, rst_cause, lock_loss_cnt, tick_us);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      step();
      if (tick_us) pulses++;
      if (!sys_rst) pulses += 100;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL no_tick_no_lock: got %0d (tick pulses + 100*sys_rst lows), want 0", pulses);
    end
  endtask

  task automatic test_lock_up();
    int n;
    pll_lock = 1'b1;
    step(); step();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: locked=%b at E+2, want 0", locked);
    end
    step();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_latency: locked=%b at E+3, want 1", locked);
    end
    n = 0;
    while (sys_rst && n < 40) begin step(); n++; end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL hold_latency: sys_rst fell after %0d cycles, want 17", n);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (tick_us !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL tick_k%0d: tick_us=%b, want %b", k, tick_us, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_lock_loss();
    int t_rst, t_run, bad;
    logic [7:0] snap;
    pll_lock = 1'b0;
    repeat (3) step();
    checks++;
    if (sys_rst !== 1'b0) begin
      errors++;
      $display("FAIL loss_early: sys_rst=%b 3 cycles after drop, want 0", sys_rst);
    end
    step();
    checks++;
    if (sys_rst !== 1'b1 || rst_cause !== 2'b01 || lock_loss_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loss_first: sys_rst=%b cause=%b cnt=%0d, want 1 01 1",
               sys_rst, rst_cause, lock_loss_cnt);
    end
    pll_lock = 1'b1;
    n_wait_run();
    bad = 0;
    snap = '0;
    for (int i = 2; i <= 300; i++) begin
      lose_relock(t_rst, t_run);
      if (t_rst != 4 || t_run != 20) bad++;
      if (i == 255) snap = lock_loss_cnt;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL loss_repeat_timing: %0d iterations off (want rst in 4, run in 20)", bad);
    end
    checks++;
    if (snap !== 8'd255) begin
      errors++;
      $display("FAIL loss_cnt_255: got %0d, want 255", snap);
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL loss_cnt_sat: got %0d, want 255", lock_loss_cnt);
    end
  endtask

  task automatic n_wait_run();
    int n;
    n = 0;
    while (sys_rst && n < 60) begin step(); n++; end
    checks++;
    if (sys_rst !== 1'b0) begin
      errors++;
      $display("FAIL wait_run_timeout: sys_rst=%b, want 0", sys_rst);
    end
  endtask

  task automatic test_button();
    int n;
    rises = 0;
    prev_rst = sys_rst;
    drive_btn(1'b0, 3); drive_btn(1'b1, 3);
    drive_btn(1'b0, 3); drive_btn(1'b1, 3);
    checks++;
    if (rises !== 0 || dut.btn_db !== 1'b1) begin
      errors++;
      $display("FAIL bounce_filtered: rises=%0d btn_db=%b, want 0 1", rises, dut.btn_db);
    end
    drive_btn(1'b0, 10);
    checks++;
    if (sys_rst !== 1'b0) begin
      errors++;
      $display("FAIL press_early: sys_rst=%b at D+10, want 0", sys_rst);
    end
    drive_btn(1'b0, 1);
    checks++;
    if (sys_rst !== 1'b1 || rst_cause !== 2'b10) begin
      errors++;
      $display("FAIL press_reset: sys_rst=%b cause=%b, want 1 10", sys_rst, rst_cause);
    end
    drive_btn(1'b0, 9);
    checks++;
    if (dut.hold_cnt_q !== 4'd0 || rises !== 1) begin
      errors++;
      $display("FAIL held_low: hold_cnt=%0d rises=%0d, want 0 1", dut.hold_cnt_q, rises);
    end
    drive_btn(1'b1, 9);
    checks++;
    if (dut.btn_db !== 1'b0) begin
      errors++;
      $display("FAIL release_early: btn_db=%b at B+9, want 0", dut.btn_db);
    end
    drive_btn(1'b1, 1);
    checks++;
    if (dut.btn_db !== 1'b1 || dut.hold_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL release_db: btn_db=%b hold_cnt=%0d, want 1 0", dut.btn_db, dut.hold_cnt_q);
    end
    n = 0;
    while (sys_rst && n < 40) begin step(); n++; end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL release_hold: sys_rst fell after %0d cycles, want 17", n);
    end
  endtask

  task automatic test_rst_mid_hold();
    int n;
    pll_lock = 1'b0;
    n = 0;
    while (!sys_rst && n < 20) begin step(); n++; end
    pll_lock = 1'b1;
    n = 0;
    while (dut.hold_cnt_q != 4'd9 && n < 60) begin step(); n++; end
    checks++;
    if (dut.hold_cnt_q !== 4'd9) begin
      errors++;
      $display("FAIL reach_hold9: hold_cnt=%0d, want 9", dut.hold_cnt_q);
    end
    rst = 1'b1;
    step();
    checks++;
    if (sys_rst !== 1'b1 || locked !== 1'b0 || rst_cause !== 2'b00 ||
        lock_loss_cnt !== 8'd0 || dut.hold_cnt_q !== 4'd0 || tick_us !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: sys_rst=%b locked=%b cause=%b cnt=%0d hold=%0d tick=%b, want 1 0 00 0 0 0",
               sys_rst, locked, rst_cause, lock_loss_cnt, dut.hold_cnt_q, tick_us);
    end
    rst = 1'b0;
    n = 0;
    while (!locked && n < 20) begin step(); n++; end
    n = 0;
    while (sys_rst && n < 40) begin step(); n++; end
    checks++;
    if (n !== 17 || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rehold_after_rst: %0d cycles cnt=%0d, want 17 0", n, lock_loss_cnt);
    end
  endtask

  task automatic test_simultaneous();
    btn_n = 1'b0;
    repeat (7) step();
    pll_lock = 1'b0;
    repeat (3) step();
    checks++;
    if (dut.press !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL coincide_align: press=%b locked=%b, want 1 0", dut.press, locked);
    end
    step();
    checks++;
    if (sys_rst !== 1'b1 || rst_cause !== 2'b01 || lock_loss_cnt !== 8'd1) begin
      errors++;
      $display("FAIL coincide_lock_wins: sys_rst=%b cause=%b cnt=%0d, want 1 01 1",
               sys_rst, rst_cause, lock_loss_cnt);
    end
    repeat (5) step();
    checks++;
    if (rst_cause !== 2'b01) begin
      errors++;
      $display("FAIL coincide_no_btn: cause=%b, want 01", rst_cause);
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_lock_loss();
    test_button();
    test_rst_mid_hold();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
